// File: rtl/vga_timing_1080p.sv
// Raster timing generator for 1920x1080p60 (2200x1125 total) on a 148.5 MHz pixel clock.
// Define VGA_TIMING_SYNC_DELAY_EN to register Hsync/Vsync one cycle behind the counters.
module vga_timing_1080p #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36
) (
   input  logic        clk_148_mhz,
   input  logic        rst_n,
   output logic [11:0] h_count_wire,
   output logic [10:0] v_count_wire,
   output logic        display_on,
   output logic        Hsync,
   output logic        Vsync,
   output logic        frame_end
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Boundaries are sized to the counter width so every compare is full-width unsigned.
   localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
   localparam logic [11:0] H_ACT_END    = 12'(H_ACTIVE);
   localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
   localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
   localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic h_wrap;
   logic v_wrap;
   logic hsync_dec;
   logic vsync_dec;

   assign h_wrap = (h_count_wire == H_LAST);
   assign v_wrap = (v_count_wire == V_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_148_mhz or negedge rst_n) begin
      if (!rst_n) begin
         h_count_wire <= '0;
         v_count_wire <= '0;
         frame_end    <= 1'b0;
      end else begin
         h_count_wire <= h_wrap ? 12'd0 : h_count_wire + 12'd1;
         if (h_wrap) begin
            v_count_wire <= v_wrap ? 11'd0 : v_count_wire + 11'd1;
         end
         // Registered so the pulse lines up with the (0,0) pixel it announces.
         frame_end <= h_wrap && v_wrap;
      end
   end

   assign display_on = (h_count_wire < H_ACT_END) && (v_count_wire < V_ACT_END);
   assign hsync_dec  = (h_count_wire >= H_SYNC_START) && (h_count_wire < H_SYNC_END);
   assign vsync_dec  = (v_count_wire >= V_SYNC_START) && (v_count_wire < V_SYNC_END);

`ifdef VGA_TIMING_SYNC_DELAY_EN
   always_ff @(posedge clk_148_mhz or negedge rst_n) begin
      if (!rst_n) begin
         Hsync <= 1'b0;
         Vsync <= 1'b0;
      end else begin
         Hsync <= hsync_dec;
         Vsync <= vsync_dec;
      end
   end
`else
   assign Hsync = hsync_dec;
   assign Vsync = vsync_dec;
`endif

endmodule

// File: tb/tb_vga_timing_1080p.sv
// Directed bench for vga_timing_1080p: full-size raster for horizontal checks and a
// reduced-size raster for vertical, frame and sync-delay behaviour.
`timescale 1ns/1ps
module tb_vga_timing_1080p;

   typedef struct {int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb;} tim_t;
   typedef struct {int h; int v; bit fe; bit hs_q; bit vs_q;} model_t;
   typedef struct {string name; int adv; int h; int v; bit disp; bit hs; bit hs_d;} vec_t;

   logic clk_148_mhz = 1'b0;
   logic rst_n = 1'b0;

   logic [11:0] h_f, h_s;
   logic [10:0] v_f, v_s;
   logic disp_f, hs_f, vs_f, fe_f;
   logic disp_s, hs_s, vs_s, fe_s;

   int n_vec = 0;
   int n_err = 0;

   tim_t t_full  = '{1920, 88, 44, 148, 1080, 4, 5, 36};
   tim_t t_small = '{16, 4, 3, 5, 12, 2, 3, 4};
   model_t mf = '{default: 0};
   model_t ms = '{default: 0};

   always #5 clk_148_mhz = ~clk_148_mhz;

   vga_timing_1080p dut (
      .clk_148_mhz (clk_148_mhz),
      .rst_n       (rst_n),
      .h_count_wire(h_f),
      .v_count_wire(v_f),
      .display_on  (disp_f),
      .Hsync       (hs_f),
      .Vsync       (vs_f),
      .frame_end   (fe_f)
   );

   // Reduced raster: 28 x 21 with the same ordering of active/porch/sync regions.
   vga_timing_1080p #(
      .H_ACTIVE(16), .H_FP(4), .H_SYNC(3), .H_BP(5),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(4)
   ) dut_s (
      .clk_148_mhz (clk_148_mhz),
      .rst_n       (rst_n),
      .h_count_wire(h_s),
      .v_count_wire(v_s),
      .display_on  (disp_s),
      .Hsync       (hs_s),
      .Vsync       (vs_s),
      .frame_end   (fe_s)
   );

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic bit hdec(model_t m, tim_t t);
      return (m.h >= t.ha + t.hf) && (m.h < t.ha + t.hf + t.hs);
   endfunction

   function automatic bit vdec(model_t m, tim_t t);
      return (m.v >= t.va + t.vf) && (m.v < t.va + t.vf + t.vs);
   endfunction

   function automatic model_t adv(model_t m, tim_t t);
      model_t n = m;
      int ht = t.ha + t.hf + t.hs + t.hb;
      int vt = t.va + t.vf + t.vs + t.vb;
      n.hs_q = hdec(m, t);
      n.vs_q = vdec(m, t);
      n.fe   = (m.h == ht - 1) && (m.v == vt - 1);
      if (m.h == ht - 1) begin
         n.h = 0;
         n.v = (m.v == vt - 1) ? 0 : m.v + 1;
      end else begin
         n.h = m.h + 1;
      end
      return n;
   endfunction

   function automatic bit exp_hs(model_t m, tim_t t);
`ifdef VGA_TIMING_SYNC_DELAY_EN
      return m.hs_q;
`else
      return hdec(m, t);
`endif
   endfunction

   function automatic bit exp_vs(model_t m, tim_t t);
`ifdef VGA_TIMING_SYNC_DELAY_EN
      return m.vs_q;
`else
      return vdec(m, t);
`endif
   endfunction

   task automatic check_small();
      check("small_h", int'(h_s), ms.h);
      check("small_v", int'(v_s), ms.v);
      check("small_display_on", int'(disp_s), int'(ms.h < t_small.ha && ms.v < t_small.va));
      check("small_hsync", int'(hs_s), int'(exp_hs(ms, t_small)));
      check("small_vsync", int'(vs_s), int'(exp_vs(ms, t_small)));
      check("small_frame_end", int'(fe_s), int'(ms.fe));
   endtask

   task automatic tick();
      @(posedge clk_148_mhz);
      mf = adv(mf, t_full);
      ms = adv(ms, t_small);
      @(negedge clk_148_mhz);
      check_small();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_h"}, int'(h_f), 0);
      check({tag, "_v"}, int'(v_f), 0);
      check({tag, "_frame_end"}, int'(fe_f), 0);
      check({tag, "_hsync"}, int'(hs_f), 0);
      check({tag, "_vsync"}, int'(vs_f), 0);
      check({tag, "_display_on"}, int'(disp_f), 1);
      check({tag, "_small_h"}, int'(h_s), 0);
      check({tag, "_small_v"}, int'(v_s), 0);
      check({tag, "_small_frame_end"}, int'(fe_s), 0);
   endtask

   initial begin
      vec_t vecs[12];
      int hs_cnt, hs_first;
      int fe_cnt, fe_origin, disp_cnt, disp_l12, vs_cnt;

      // adv = edges since previous row; hs = undelayed decode, hs_d = registered decode.
      vecs[0]  = '{"first_edge",  1,    1,    0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{"last_active", 1918, 1919, 0, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{"first_blank", 1,    1920, 0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{"pre_hsync",   87,   2007, 0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{"hsync_start", 1,    2008, 0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{"hsync_2009",  1,    2009, 0, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{"hsync_last",  42,   2051, 0, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{"hsync_end",   1,    2052, 0, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{"post_hsync",  1,    2053, 0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{"line_end",    146,  2199, 0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{"line_wrap",   1,    0,    1, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{"line1_px1",   1,    1,    1, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0;
      repeat (3) @(negedge clk_148_mhz);
      check_reset_state("reset");
      check_small();

      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         repeat (vecs[i].adv) tick();
         check({vecs[i].name, "_h"}, int'(h_f), vecs[i].h);
         check({vecs[i].name, "_v"}, int'(v_f), vecs[i].v);
         check({vecs[i].name, "_display_on"}, int'(disp_f), int'(vecs[i].disp));
`ifdef VGA_TIMING_SYNC_DELAY_EN
         check({vecs[i].name, "_hsync"}, int'(hs_f), int'(vecs[i].hs_d));
`else
         check({vecs[i].name, "_hsync"}, int'(hs_f), int'(vecs[i].hs));
`endif
         check({vecs[i].name, "_vsync"}, int'(vs_f), 0);
         check({vecs[i].name, "_frame_end"}, int'(fe_f), 0);
      end

      // One full line: Hsync width and position of its first high sample.
      hs_cnt = 0;
      hs_first = -1;
      for (int i = 0; i < 2200; i++) begin
         tick();
         if (hs_f) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(h_f);
         end
      end
      check("hsync_width", hs_cnt, 44);
`ifdef VGA_TIMING_SYNC_DELAY_EN
      check("hsync_first_h", hs_first, 2009);
`else
      check("hsync_first_h", hs_first, 2008);
`endif
      check("line2_h", int'(h_f), 1);
      check("line2_v", int'(v_f), 2);

      // One whole reduced frame (28*21 = 588 cycles).
      fe_cnt = 0; fe_origin = 0; disp_cnt = 0; disp_l12 = 0; vs_cnt = 0;
      for (int i = 0; i < 588; i++) begin
         tick();
         if (fe_s) begin
            fe_cnt++;
            if (h_s == 12'd0 && v_s == 11'd0) fe_origin++;
         end
         if (disp_s) disp_cnt++;
         if (disp_s && v_s == 11'd12) disp_l12++;
         if (vs_s) vs_cnt++;
      end
      check("small_frame_end_count", fe_cnt, 1);
      check("small_frame_end_at_origin", fe_origin, 1);
      check("small_display_cycles", disp_cnt, 192);
      check("small_display_line12", disp_l12, 0);
      check("small_vsync_cycles", vs_cnt, 84);

      repeat (411) tick();
      check("pre_reset_h", int'(h_f), 1000);
      check("pre_reset_v", int'(v_f), 2);

      // Mid-line reset must clear outputs before any clock edge.
      rst_n = 1'b0;
      #1;
      check_reset_state("async_reset");
      repeat (2) @(posedge clk_148_mhz);
      @(negedge clk_148_mhz);
      check_reset_state("held_reset");

      rst_n = 1'b1;
      mf = '{default: 0};
      ms = '{default: 0};
      tick();
      check("restart_h", int'(h_f), 1);
      check("restart_v", int'(v_f), 0);
      check("restart_display_on", int'(disp_f), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
